// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq: iterative forward SubBytes engine for the AES encryption round loop.
//
// A 128-bit state is captured over a valid/ready handshake, LANES bytes per cycle are replaced
// by their forward S-box value, and the result is offered over a second valid/ready handshake.
// Byte i of a state lives at data[127-8i -: 8] (row i%4, column i/4).
//
// Optional build macro AES_SUB_BYTES_SHIFT_ROWS_EN: when defined, ShiftRows is folded into the
// load of out_data_o (same latency); when undefined, out_data_o is the pure SubBytes result.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   input state valid
//   in_ready_o   engine idle and able to accept a state
//   in_data_i    input state
//   out_valid_o  result valid (held until out_ready_i)
//   out_ready_i  downstream accepts result
//   out_data_o   result state
//   busy_o       substitution in progress
module aes_sub_bytes_seq #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] out_data_o,
   output logic         busy_o
);

   // Guarded so an illegal LANES of 0 reports the check below instead of dividing by zero.
   localparam int unsigned PASSES = (LANES == 0) ? 1 : 16 / LANES;
   localparam int unsigned CntW   = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(PASSES - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   // Forward S-box, row 0x0_ first. The concatenation puts sbox(0) in the top entry, so the
   // table is indexed with the bitwise complement of the byte (255 - x == ~x).
   localparam logic [255:0][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [15:0][7:0] work_q, work_d;  // work_q[15-i] is byte i
   logic [127:0]     out_q, out_d;
   logic [15:0][7:0] sub_state;       // working state with this pass's lanes substituted
   logic             last_pass;
   logic [3:0]       lane_sel [LANES];
   logic [7:0]       lane_in  [LANES];
   logic [7:0]       lane_sub [LANES];

   assign last_pass = (cnt_q == LastCnt);

   // One combinational S-box per lane; lane g handles byte cnt*LANES+g.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_sel[g] = 4'(32'(cnt_q) * LANES + 32'(g));
      assign lane_in[g]  = work_q[4'd15 - lane_sel[g]];
      assign lane_sub[g] = SBOX[~lane_in[g]];
   end

   // Byte j belongs to pass j/LANES and is fed by lane j%LANES.
   for (genvar j = 0; j < 16; j++) begin : g_byte
      assign sub_state[15-j] = (cnt_q == CntW'(j / LANES)) ? lane_sub[j % LANES] : work_q[15-j];
   end

`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
   // Out row r, col c takes sub row r, col (c+r)%4.
   function automatic logic [127:0] out_map(input logic [15:0][7:0] s);
      logic [15:0][7:0] r;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned rw = 0; rw < 4; rw++) begin
            r[4'(15 - (rw + 4 * c))] = s[4'(15 - (rw + 4 * ((c + rw) % 4)))];
         end
      end
      return r;
   endfunction
`else
   function automatic logic [127:0] out_map(input logic [15:0][7:0] s);
      return s;
   endfunction
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid_i)  state_d = StBusy;
         StBusy:  if (last_pass)   state_d = StDone;
         StDone:  if (out_ready_i) state_d = StIdle;
         default:                  state_d = StIdle;
      endcase
   end

   // Outputs; in_ready is gated by reset so it reads 0 while rst_n is held low.
   always_comb begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b0;
      unique case (state_q)
         StIdle:  in_ready_o  = rst_n;
         StBusy:  busy_o      = 1'b1;
         StDone:  out_valid_o = 1'b1;
         default: ;
      endcase
   end

   assign out_data_o = out_q;

   // Datapath next-state
   always_comb begin
      work_d = work_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               work_d = in_data_i;
               cnt_d  = '0;
            end
         end
         StBusy: begin
            work_d = sub_state;
            if (last_pass) begin
               out_d = out_map(sub_state);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         work_q <= '0;
         out_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         work_q <= work_d;
         out_q  <= out_d;
      end
   end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb_aes_sub_bytes_seq: scoreboard bench for aes_sub_bytes_seq.
// Three instances (LANES 4, 1, 16) share stimulus; each has its own expected-result queue,
// filled on its input handshake and drained on its output handshake. The reference S-box is
// computed from GF(2^8) arithmetic, and the inverse S-box from the inverse affine map.
module tb_aes_sub_bytes_seq;

   localparam int NDut   = 3;
   localparam int Passes = 4;  // main instance uses LANES=4

   typedef struct {
      logic [127:0] din;
      logic [127:0] exp;
   } sb_item_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [127:0] in_data;
   logic         out_ready;
   logic         rdy   [NDut];
   logic         vld   [NDut];
   logic         bsy   [NDut];
   logic [127:0] odata [NDut];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic [7:0] fwd  [256];
   logic [7:0] ginv [256];
   sb_item_t   exp_q [NDut][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_sub_bytes_seq #(.LANES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
      .in_data_i(in_data), .out_valid_o(vld[0]), .out_ready_i(out_ready),
      .out_data_o(odata[0]), .busy_o(bsy[0]));
   aes_sub_bytes_seq #(.LANES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
      .in_data_i(in_data), .out_valid_o(vld[1]), .out_ready_i(out_ready),
      .out_data_o(odata[1]), .busy_o(bsy[1]));
   aes_sub_bytes_seq #(.LANES(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
      .in_data_i(in_data), .out_valid_o(vld[2]), .out_ready_i(out_ready),
      .out_data_o(odata[2]), .busy_o(bsy[2]));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      return ginv[rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05];
   endfunction

   function automatic logic [7:0] get_byte(input logic [127:0] d, input int i);
      return 8'(d >> (8 * (15 - i)));
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d);
      logic [7:0]   s [16];
      logic [127:0] r = '0;
      for (int i = 0; i < 16; i++) s[i] = fwd[get_byte(d, i)];
      for (int i = 0; i < 16; i++) begin
`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
         r = r | (128'(s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]) << (8 * (15 - i)));
`else
         r = r | (128'(s[i]) << (8 * (15 - i)));
`endif
      end
      return r;
   endfunction

   // Handshakes are judged at the falling edge; the rising edge that follows completes them.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NDut; k++) exp_q[k].delete();
      end else begin
         for (int k = 0; k < NDut; k++) begin
            if (vld[k] && out_ready) begin
               if (exp_q[k].size() == 0) begin
                  check($sformatf("dut%0d_unexpected_out", k), 128'd1, 128'd0);
               end else begin
                  sb_item_t it;
                  logic [7:0] b0;
                  it = exp_q[k].pop_front();
                  b0 = get_byte(odata[k], 0);
                  check($sformatf("dut%0d_data", k), odata[k], it.exp);
                  check($sformatf("dut%0d_roundtrip", k), 128'(inv_sbox(b0)),
                        128'(get_byte(it.din, 0)));
                  case (get_byte(it.din, 0))
                     8'h53:   check($sformatf("dut%0d_spot53", k), 128'(b0), 128'h ed);
                     8'hff:   check($sformatf("dut%0d_spotff", k), 128'(b0), 128'h 16);
                     8'h01:   check($sformatf("dut%0d_spot01", k), 128'(b0), 128'h 7c);
                     default: ;
                  endcase
               end
            end
            if (in_valid && rdy[k]) begin
               sb_item_t it;
               it.din = in_data;
               it.exp = model(in_data);
               exp_q[k].push_back(it);
            end
         end
      end
   end

   // Drive a state and wait for the LANES=4 instance (or all instances) to take it.
   // in_valid stays high on return; acc is the cycle number of the accept edge.
   task automatic send(input logic [127:0] d, input bit all, output int acc);
      bit ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      acc      = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (rdy[0] && (!all || (rdy[1] && rdy[2]))) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         check("send_timeout", 128'd0, 128'd1);
         return;
      end
      acc = cyc;
      @(posedge clk);
      #1;
   endtask

   // Returns the number of rising edges, counting the accept edge, until out_valid is high.
   task automatic wait_valid(output int edges);
      edges = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (vld[0]) begin
            edges = k + 1;
            return;
         end
      end
      check("valid_timeout", 128'd0, 128'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      end
      for (int k = 0; k < NDut; k++) check($sformatf("dut%0d_drained", k), 128'(exp_q[k].size()), 0);
   endtask

   initial begin
      int           acc, edges;
      int           acc_t [6];
      logic [127:0] d, e;

      for (int a = 0; a < 256; a++) ginv[a] = 8'h00;
      for (int a = 1; a < 256; a++)
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) ginv[a] = 8'(b);
      for (int a = 0; a < 256; a++) begin
         logic [7:0] v;
         v = ginv[a];
         fwd[a] = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
      end

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 128'(rdy[0]), 0);
      check("rst_out_valid", 128'(vld[0]), 0);
      check("rst_out_data", odata[0], 0);
      check("rst_busy", 128'(bsy[0]), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 128'(rdy[0]), 1);

      // All-zero state, latency
      @(posedge clk); #1;
      out_ready = 1'b1;
      send('0, 0, acc);
      in_valid = 1'b0;
      check("busy_after_accept", 128'(bsy[0]), 1);
      check("ready_low_busy", 128'(rdy[0]), 0);
      wait_valid(edges);
      check("latency", 128'(edges), 128'(Passes + 1));
      check("zero_block", odata[0], {16{8'h63}});
      @(posedge clk); #1;
      check("valid_drops", 128'(vld[0]), 0);

      // Known vector
      send(128'h00112233445566778899aabbccddeeff, 0, acc);
      in_valid = 1'b0;
      wait_valid(edges);
`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
      check("vector", odata[0], 128'h63fcac161bee28c3c4c193f54b8233ea);
`else
      check("vector", odata[0], 128'h638293c31bfc33f5c4eeacea4bc12816);
`endif
      @(posedge clk); #1;

      // Backpressure with a second, ignored input
      out_ready = 1'b0;
      d = {$urandom, $urandom, $urandom, $urandom};
      e = model(d);
      send(d, 0, acc);
      in_valid = 1'b0;
      wait_valid(edges);
      in_valid = 1'b1;
      in_data  = ~d;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("bp_data", odata[0], e);
         check("bp_valid", 128'(vld[0]), 1);
         check("bp_ready", 128'(rdy[0]), 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_after_hs", 128'(vld[0]), 0);
      check("bp_ready_after_hs", 128'(rdy[0]), 1);
      check("bp_single_out", 128'(exp_q[0].size()), 0);

      // Reset during the second BUSY cycle
      send({$urandom, $urandom, $urandom, $urandom}, 0, acc);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("midrst_busy_before", 128'(bsy[0]), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 128'(rdy[0]), 0);
      check("midrst_out_valid", 128'(vld[0]), 0);
      check("midrst_busy", 128'(bsy[0]), 0);
      check("midrst_out_data", odata[0], 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 0, acc);
      in_valid = 1'b0;
      wait_valid(edges);
      check("after_rst_data", odata[0], model(d));
      @(posedge clk); #1;

      // Back-to-back with in_valid held high
      for (int b = 0; b < 6; b++) send({$urandom, $urandom, $urandom, $urandom}, 0, acc_t[b]);
      in_valid = 1'b0;
      for (int b = 1; b < 6; b++)
         check($sformatf("b2b_spacing%0d", b), 128'(acc_t[b] - acc_t[b-1]), 128'(Passes + 2));
      drain();

      // Lane-0 sweep of every byte value across all instances
      for (int v = 0; v < 256; v++) begin
         send({8'(v), 120'h0}, 1, acc);
         in_valid = 1'b0;
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_sub_bytes_seq.md
Name: aes_sub_bytes_seq

Overview:
- Iterative forward SubBytes engine for the AES-256 encryption datapath. It is the encrypt-side counterpart of the decryption inverse S-box.
- Accepts one 128-bit state over a valid/ready handshake. Substitutes LANES bytes per cycle through a forward S-box (FIPS-197). Returns the 128-bit result over a valid/ready handshake.
- Sits between AddRoundKey and MixColumns in the encryption round loop. Its output must round-trip byte-for-byte through the existing inverse S-box.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is a compile-time error.
- PASSES, 16/LANES, derived (localparam), number of BUSY cycles per block.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input state valid.
- in_ready  out  1  engine can accept a state.
- in_data  in  128  input state; byte i = in_data[127-8i -: 8]; byte i is row i%4, column i/4.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  128  result state, same byte ordering.
- busy  out  1  high in BUSY state.

Behaviour:
- Reset values: in_ready=0 while rst_n low, 1 in first cycle after release. out_valid=0, out_data=128'h0, busy=0, FSM=IDLE, pass counter=0, working register=0.
- FSM IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the working register, clear the counter, go to BUSY.
- FSM BUSY: in_ready=0, busy=1. Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register are replaced with S-box(byte). cnt increments.
- When cnt==PASSES-1 in BUSY, the last lanes are written and the FSM goes to DONE. out_data is loaded with the final state and out_valid=1 on the next edge.
- Latency: accept edge to out_valid high = PASSES+1 edges (LANES=4: 5 cycles; LANES=16: 2 cycles).
- FSM DONE: out_valid=1, out_data held stable, in_ready=0. On out_valid&&out_ready, out_valid drops and the FSM goes to IDLE.
- No input accepted in the same cycle as the output handshake, so there is one bubble between blocks.
- Backpressure: out_ready low holds out_valid and out_data unchanged indefinitely.
- in_valid while not in IDLE is ignored; in_data is not sampled.
- Counter width is clog2(PASSES), minimum 1 bit. The counter never wraps past PASSES-1; it clears on entry to BUSY.
- S-box is a combinational 256-entry forward table, instantiated LANES times. Only the working register and out_data are registered.
- rst_n low mid-BUSY or mid-DONE: immediate return to reset values. The partial state is discarded, and no out_valid pulse is produced.

Optional Feature:
- Macro: AES_SUB_BYTES_SHIFT_ROWS_EN.
- Defined: ShiftRows is applied combinationally when loading out_data, with out row r, col c = sub row r, col (c+r)%4. Latency is unchanged, and the block then performs SubBytes followed by ShiftRows.
- Undefined: out_data = pure SubBytes result.

Test Plan:
- Reset, then in_data=128'h0 with out_ready=1 -> out_data=128'h636363...63 (16 bytes of 63); out_valid rises exactly PASSES+1 edges after the accept edge.
- in_data=00112233445566778899aabbccddeeff, macro undefined -> out_data=638293c31bfc33f5c4eeacea4bc12816. Same input with macro defined -> 63fcac161bee28c3c4c193f54b8233ea.
- Hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, second in_valid ignored. Raise out_ready -> one handshake, then in_ready=1 the next cycle.
- Assert rst_n=0 during the 2nd BUSY cycle (LANES=4) -> outputs return to reset values asynchronously. A new block after release produces the correct result, with no stale bytes.
- Sweep all 256 byte values in lane 0 (others 00), for LANES in {1,4,16} -> each result byte passed through the existing InverseSbox equals the original. Spot checks: 53->ed, ff->16, 01->7c.
- Back-to-back blocks with in_valid held high -> throughput of one block per PASSES+2 cycles, no lost or duplicated outputs.
